// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, zero-register index, grant type and count-width helper for the writeback arbiter
package rf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG = 0;
  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} gnt_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry {addr,data} queue; push/pop in, head/full/empty/count out, per-entry valid/addr out for hazard matching
module wb_fifo
  import rf_pkg::*;
#(
  parameter int AW = ADDR_W_DEF,
  parameter int DW = DATA_W_DEF,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [AW-1:0]              head_addr,
  output logic [DW-1:0]              head_data,
  output logic                       full,
  output logic                       empty,
  output logic [CW-1:0]              count,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH-1:0][AW-1:0]   ent_addr
);
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head_addr = ent_addr[rd_ptr];
  assign head_data = data_q[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(do_pop);
      wr_ptr <= wr_ptr + PW'(do_push);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) begin
      ent_addr[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_v
    logic [PW-1:0] off;
    // slot i is live when its distance from the read pointer is below the occupancy
    assign off = PW'(i) - rd_ptr;
    assign ent_valid[i] = CW'(off) < count;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin merge of writeback channels a/b onto regwrite/writeaddr/writedata, with rs/rt hazard query and idle
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              regwrite,
  output logic [ADDR_W-1:0] writeaddr,
  output logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              rs_pending,
  output logic              rt_pending,
  output logic              idle
);
  localparam int CW = cnt_w(DEPTH);
  logic a_full, b_full, a_empty, b_empty, a_push, b_push, a_pop, b_pop;
  logic [CW-1:0] a_count, b_count;
  logic [ADDR_W-1:0] a_head_addr, b_head_addr;
  logic [DATA_W-1:0] a_head_data, b_head_data;
  logic [DEPTH-1:0] a_ent_valid, b_ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] a_ent_addr, b_ent_addr;
  gnt_e last;
  assign a_ready = ~a_full;
  assign b_ready = ~b_full;
  // writes to the zero register complete the handshake but are dropped here
  assign a_push = a_valid & a_ready & (a_addr != ADDR_W'(ZERO_REG));
  assign b_push = b_valid & b_ready & (b_addr != ADDR_W'(ZERO_REG));
  assign a_pop = ~a_empty & (b_empty | last == GNT_B);
  assign b_pop = ~b_empty & ~a_pop;
  assign idle = a_count == '0 && b_count == '0 && !regwrite;
  wb_fifo #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(DEPTH)) u_a (
    .clk(clk), .rst(rst), .push(a_push), .push_addr(a_addr), .push_data(a_data), .pop(a_pop),
    .head_addr(a_head_addr), .head_data(a_head_data), .full(a_full), .empty(a_empty),
    .count(a_count), .ent_valid(a_ent_valid), .ent_addr(a_ent_addr)
  );
  wb_fifo #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .push(b_push), .push_addr(b_addr), .push_data(b_data), .pop(b_pop),
    .head_addr(b_head_addr), .head_data(b_head_data), .full(b_full), .empty(b_empty),
    .count(b_count), .ent_valid(b_ent_valid), .ent_addr(b_ent_addr)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regwrite <= 1'b0;
      writeaddr <= '0;
      writedata <= '0;
      last <= GNT_B;
    end else begin
      regwrite <= a_pop | b_pop;
      if (a_pop | b_pop) begin
        writeaddr <= a_pop ? a_head_addr : b_head_addr;
        writedata <= a_pop ? a_head_data : b_head_data;
        last <= a_pop ? GNT_A : GNT_B;
      end
    end
  always_comb begin
    rs_pending = regwrite & (writeaddr == rs);
    rt_pending = regwrite & (writeaddr == rt);
    for (int i = 0; i < DEPTH; i++) begin
      rs_pending |= (a_ent_valid[i] & (a_ent_addr[i] == rs)) | (b_ent_valid[i] & (b_ent_addr[i] == rs));
      rt_pending |= (a_ent_valid[i] & (a_ent_addr[i] == rt)) | (b_ent_valid[i] & (b_ent_addr[i] == rt));
    end
    rs_pending &= rs != ADDR_W'(ZERO_REG);
    rt_pending &= rt != ADDR_W'(ZERO_REG);
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: table-driven, directed and randomized queue-model checks of rf_wb_arbiter
module tb_rf_wb_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 2;
  logic clk = 0, rst = 1;
  logic a_valid = 0, b_valid = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0, rs = '0, rt = '0, writeaddr;
  logic [DW-1:0] a_data = '0, b_data = '0, writedata;
  logic a_ready, b_ready, regwrite, rs_pending, rt_pending, idle;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .regwrite(regwrite), .writeaddr(writeaddr), .writedata(writedata),
    .rs(rs), .rt(rt), .rs_pending(rs_pending), .rt_pending(rt_pending), .idle(idle)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct {
    logic r, av, bv, rw, ar, br, id, sp, tp;
    logic [AW-1:0] aa, ba, qs, qt, wa;
    logic [DW-1:0] ad, bd, wd;
  } vec_t;
  vec_t vt[14];
  function automatic vec_t v(input int r, av, aa, ad, bv, ba, bd, qs, qt, rw, wa, wd, ar, br, id, sp, tp);
    vec_t x;
    x.r = r[0]; x.av = av[0]; x.aa = AW'(aa); x.ad = DW'(ad);
    x.bv = bv[0]; x.ba = AW'(ba); x.bd = DW'(bd); x.qs = AW'(qs); x.qt = AW'(qt);
    x.rw = rw[0]; x.wa = AW'(wa); x.wd = DW'(wd);
    x.ar = ar[0]; x.br = br[0]; x.id = id[0]; x.sp = sp[0]; x.tp = tp[0];
    return x;
  endfunction
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t qa[$], qb[$];
  bit m_last_b, m_rw, acc_a, acc_b;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  function automatic void m_reset();
    qa.delete(); qb.delete();
    m_last_b = 1; m_rw = 0; m_wa = '0; m_wd = '0; acc_a = 0; acc_b = 0;
  endfunction
  function automatic void m_step();
    bit ra, rb;
    ent_t e, n;
    ra = qa.size() < DEPTH;
    rb = qb.size() < DEPTH;
    m_rw = 0;
    if (qa.size() > 0 && (qb.size() == 0 || m_last_b)) begin
      e = qa.pop_front(); m_last_b = 0; m_rw = 1;
    end else if (qb.size() > 0) begin
      e = qb.pop_front(); m_last_b = 1; m_rw = 1;
    end
    if (m_rw) begin
      m_wa = e.a; m_wd = e.d;
    end
    acc_a = a_valid && ra;
    acc_b = b_valid && rb;
    if (acc_a && a_addr != 0) begin
      n.a = a_addr; n.d = a_data; qa.push_back(n);
    end
    if (acc_b && b_addr != 0) begin
      n.a = b_addr; n.d = b_data; qb.push_back(n);
    end
  endfunction
  function automatic bit m_pend(input logic [AW-1:0] r);
    bit p;
    p = m_rw && m_wa == r;
    foreach (qa[i]) p |= qa[i].a == r;
    foreach (qb[i]) p |= qb[i].a == r;
    return p && r != 0;
  endfunction
  task automatic m_check(input string t);
    check({t, ".rw"}, 64'(regwrite), 64'(m_rw));
    check({t, ".wa"}, 64'(writeaddr), 64'(m_wa));
    check({t, ".wd"}, 64'(writedata), 64'(m_wd));
    check({t, ".ar"}, 64'(a_ready), 64'(qa.size() < DEPTH));
    check({t, ".br"}, 64'(b_ready), 64'(qb.size() < DEPTH));
    check({t, ".idle"}, 64'(idle), 64'(qa.size() == 0 && qb.size() == 0 && !m_rw));
    check({t, ".rsp"}, 64'(rs_pending), 64'(m_pend(rs)));
    check({t, ".rtp"}, 64'(rt_pending), 64'(m_pend(rt)));
  endtask
  task automatic run_cycle(input string t);
    @(posedge clk);
    m_step();
    #1;
    m_check(t);
  endtask
  task automatic do_reset(input string t);
    rst = 1; a_valid = 0; b_valid = 0;
    #1;
    check({t, ".rw"}, 64'(regwrite), 64'(0));
    check({t, ".wa"}, 64'(writeaddr), 64'(0));
    check({t, ".wd"}, 64'(writedata), 64'(0));
    check({t, ".ar"}, 64'(a_ready), 64'(1));
    check({t, ".br"}, 64'(b_ready), 64'(1));
    check({t, ".idle"}, 64'(idle), 64'(1));
    m_reset();
    @(posedge clk);
    #1 rst = 0;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end
  initial begin
    int ai, bi;
    bit saw;
    logic [AW-1:0] seen[$];
    vt[0]  = v(0, 1, 3, 'h11, 0, 0, 0,    0, 0, 0, 0, 0,    1, 1, 0, 0, 0);
    vt[1]  = v(0, 0, 0, 0,    0, 0, 0,    0, 0, 1, 3, 'h11, 1, 1, 0, 0, 0);
    vt[2]  = v(0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 3, 'h11, 1, 1, 1, 0, 0);
    vt[3]  = v(0, 0, 0, 0,    1, 0, 'hFF, 0, 0, 0, 3, 'h11, 1, 1, 1, 0, 0);
    vt[4]  = v(0, 1, 7, 'h77, 0, 0, 0,    7, 0, 0, 3, 'h11, 1, 1, 0, 1, 0);
    vt[5]  = v(0, 0, 0, 0,    0, 0, 0,    7, 0, 1, 7, 'h77, 1, 1, 0, 1, 0);
    vt[6]  = v(0, 0, 0, 0,    0, 0, 0,    7, 0, 0, 7, 'h77, 1, 1, 1, 0, 0);
    vt[7]  = v(1, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0,    1, 1, 1, 0, 0);
    vt[8]  = v(0, 1, 1, 'hA1, 1, 5, 'hB5, 5, 1, 0, 0, 0,    1, 1, 0, 1, 1);
    vt[9]  = v(0, 1, 2, 'hA2, 1, 6, 'hB6, 5, 1, 1, 1, 'hA1, 1, 0, 0, 1, 1);
    vt[10] = v(0, 0, 0, 0,    0, 0, 0,    5, 1, 1, 5, 'hB5, 1, 1, 0, 1, 0);
    vt[11] = v(0, 0, 0, 0,    0, 0, 0,    5, 1, 1, 2, 'hA2, 1, 1, 0, 0, 0);
    vt[12] = v(0, 0, 0, 0,    0, 0, 0,    5, 1, 1, 6, 'hB6, 1, 1, 0, 0, 0);
    vt[13] = v(0, 0, 0, 0,    0, 0, 0,    5, 1, 0, 6, 'hB6, 1, 1, 1, 0, 0);
    do_reset("rst0");
    foreach (vt[i]) begin
      rst = vt[i].r;
      a_valid = vt[i].av; a_addr = vt[i].aa; a_data = vt[i].ad;
      b_valid = vt[i].bv; b_addr = vt[i].ba; b_data = vt[i].bd;
      rs = vt[i].qs; rt = vt[i].qt;
      @(posedge clk);
      #1 a_valid = 0; b_valid = 0; rst = 0;
      #1;
      check($sformatf("v%0d.rw", i), 64'(regwrite), 64'(vt[i].rw));
      check($sformatf("v%0d.wa", i), 64'(writeaddr), 64'(vt[i].wa));
      check($sformatf("v%0d.wd", i), 64'(writedata), 64'(vt[i].wd));
      check($sformatf("v%0d.ar", i), 64'(a_ready), 64'(vt[i].ar));
      check($sformatf("v%0d.br", i), 64'(b_ready), 64'(vt[i].br));
      check($sformatf("v%0d.idle", i), 64'(idle), 64'(vt[i].id));
      check($sformatf("v%0d.rsp", i), 64'(rs_pending), 64'(vt[i].sp));
      check($sformatf("v%0d.rtp", i), 64'(rt_pending), 64'(vt[i].tp));
    end
    do_reset("rst1");
    ai = 0; bi = 0; saw = 0;
    for (int c = 0; c < 40 && ai < 4; c++) begin
      a_valid = 1; a_addr = AW'(11 + ai); a_data = DW'(32'hC0 + ai);
      b_valid = 1; b_addr = AW'(20 + bi % 8); b_data = DW'(32'hD0 + bi);
      run_cycle("bp");
      if (regwrite && writeaddr >= 11 && writeaddr <= 14) seen.push_back(writeaddr);
      if (a_valid && !a_ready) saw = 1;
      if (acc_a) ai++;
      if (acc_b) bi++;
    end
    check("bp.all_accepted", 64'(ai), 64'(4));
    check("bp.stalled", 64'(saw), 64'(1));
    a_valid = 0; b_valid = 0;
    for (int c = 0; c < 8; c++) begin
      run_cycle("bp.drain");
      if (regwrite && writeaddr >= 11 && writeaddr <= 14) seen.push_back(writeaddr);
    end
    check("bp.count", 64'(seen.size()), 64'(4));
    foreach (seen[k]) check($sformatf("bp.order%0d", k), 64'(seen[k]), 64'(11 + k));
    do_reset("rst2");
    a_valid = 1; a_addr = 1; a_data = 'hE1; b_valid = 1; b_addr = 2; b_data = 'hE2;
    run_cycle("mid0");
    a_addr = 3; a_data = 'hE3; b_addr = 4; b_data = 'hE4;
    run_cycle("mid1");
    check("mid.queued", 64'(qa.size() + qb.size()), 64'(3));
    do_reset("rst_mid");
    for (int c = 0; c < 5; c++) run_cycle("post_rst");
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset("rst_rand");
      if (!a_valid || acc_a) begin
        a_valid = $urandom_range(0, 2) != 0;
        a_addr = AW'($urandom_range(0, 7));
        a_data = $urandom;
      end
      if (!b_valid || acc_b) begin
        b_valid = $urandom_range(0, 2) != 0;
        b_addr = AW'($urandom_range(0, 7));
        b_data = $urandom;
      end
      rs = AW'($urandom_range(0, 7));
      rt = AW'($urandom_range(0, 7));
      run_cycle("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
